// File: rtl/cube_root_seq.sv
// rtl/cube_root_seq.sv - sequential bit-serial integer cube root with start/done handshake
//
// Computes root = floor(cbrt(data_in)) and remainder = data_in - root^3.
// One root bit is resolved per SQ/CUBE state pair. A single multiplier is
// shared: SQ forms cand*cand and CUBE forms sq*cand.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only in IDLE or DONE
//   data_in    unsigned operand (IN_W bits), captured on the accepting edge
//   busy       high while in SQ or CUBE
//   done       one-cycle pulse, high while in DONE
//   root       floor cube root (ROOT_W bits), updated on DONE entry only
//   remainder  data_in - root^3 (IN_W bits), updated on DONE entry only
//   exact      (only with CUBE_ROOT_EXACT_EN defined) remainder was zero
//
// Optional feature macro: CUBE_ROOT_EXACT_EN

module cube_root_seq #(
   parameter int IN_W = 12
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [IN_W-1:0]             data_in,
   output logic                        busy,
   output logic                        done,
   output logic [((IN_W+2)/3)-1:0]     root,
`ifdef CUBE_ROOT_EXACT_EN
   output logic [IN_W-1:0]             remainder,
   output logic                        exact
`else
   output logic [IN_W-1:0]             remainder
`endif
);

   localparam int ROOT_W = (IN_W + 2) / 3;
   localparam int SQ_W   = 2 * ROOT_W;
   localparam int CUBE_W = 3 * ROOT_W;
   localparam int IDX_W  = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQ   = 2'd1,
      CUBE = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state, next_state;

   logic [IN_W-1:0]   x;
   logic [ROOT_W-1:0] acc;
   logic [CUBE_W-1:0] best_cube;
   logic [IDX_W-1:0]  idx;
   logic [SQ_W-1:0]   sq;

   logic [ROOT_W-1:0] cand;
   logic [CUBE_W-1:0] mul_a;
   logic [CUBE_W-1:0] prod;
   logic [CUBE_W-1:0] x_ext;
   logic              fit;
   logic [ROOT_W-1:0] new_acc;
   logic [CUBE_W-1:0] new_best;
   logic [CUBE_W-1:0] diff;
   logic              accept;

   assign accept = ((state == IDLE) || (state == DONE)) && start;

   // Candidate keeps all already-accepted bits and trials the current one.
   assign cand  = acc | (ROOT_W'(1) << idx);
   assign x_ext = CUBE_W'(x);

   // Shared multiplier: SQ squares the candidate, CUBE multiplies the
   // stored square by the candidate. The product always fits in CUBE_W.
   assign mul_a = (state == SQ) ? CUBE_W'(cand) : CUBE_W'(sq);
   assign prod  = mul_a * CUBE_W'(cand);

   assign fit      = (prod <= x_ext);
   assign new_acc  = fit ? cand : acc;
   assign new_best = fit ? prod : best_cube;
   assign diff     = x_ext - new_best;

   assign busy = (state == SQ) || (state == CUBE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start) next_state = SQ;
         SQ:   next_state = CUBE;
         CUBE: next_state = (idx == '0) ? DONE : SQ;
         DONE: next_state = start ? SQ : IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x         <= '0;
         acc       <= '0;
         best_cube <= '0;
         idx       <= '0;
         sq        <= '0;
         root      <= '0;
         remainder <= '0;
         done      <= 1'b0;
`ifdef CUBE_ROOT_EXACT_EN
         exact     <= 1'b0;
`endif
      end else begin
         done <= (next_state == DONE);
         if (accept) begin
            x         <= data_in;
            acc       <= '0;
            best_cube <= '0;
            idx       <= IDX_W'(ROOT_W - 1);
         end else if (state == SQ) begin
            sq <= prod[SQ_W-1:0];
         end else if (state == CUBE) begin
            acc       <= new_acc;
            best_cube <= new_best;
            if (idx != '0) begin
               idx <= idx - 1'b1;
            end else begin
               // Last bit resolved: publish the result as DONE is entered.
               root      <= new_acc;
               remainder <= diff[IN_W-1:0];
`ifdef CUBE_ROOT_EXACT_EN
               exact     <= (diff == '0);
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_cube_root_seq.sv
// tb/tb_cube_root_seq.sv - randomized self-checking bench for cube_root_seq
module tb_cube_root_seq;

   localparam int IN_W   = 12;
   localparam int ROOT_W = (IN_W + 2) / 3;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [IN_W-1:0]   data_in;
   logic              busy;
   logic              done;
   logic [ROOT_W-1:0] root;
   logic [IN_W-1:0]   remainder;
`ifdef CUBE_ROOT_EXACT_EN
   logic              exact;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   cube_root_seq #(.IN_W(IN_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .data_in   (data_in),
      .busy      (busy),
      .done      (done),
      .root      (root),
`ifdef CUBE_ROOT_EXACT_EN
      .remainder (remainder),
      .exact     (exact)
`else
      .remainder (remainder)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: largest r with r^3 <= x, by plain search.
   function automatic int cbrt_ref(input int xv);
      int r = 0;
      while ((r + 1) * (r + 1) * (r + 1) <= xv) r++;
      return r;
   endfunction

   // Drive start/data_in so the next rising edge accepts the operand.
   task automatic present(input int xv);
      start   = 1'b1;
      data_in = IN_W'(xv);
   endtask

   // Called with the accepting edge about to occur. Waits for done, checks
   // latency, busy duration, result stability and the result itself.
   // noise: wiggle start/data_in while busy. chain: on the done cycle present
   // next_x for a back-to-back accept instead of dropping start.
   task automatic run_op(input int xv, input bit noise, input bit chain, input int next_x,
                         input int prev_root, input int prev_rem);
      int lat, busy_cnt, r;
      @(posedge clk); #1;
      lat = 1; busy_cnt = 0;
      start = 1'b0;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         check("stable_root", root, prev_root);
         check("stable_rem", remainder, prev_rem);
         if (noise) begin
            start   = 1'($urandom);
            data_in = IN_W'($urandom);
         end
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, 9);
      check("busy_cycles", busy_cnt, 8);
      check("busy_at_done", busy, 0);
      r = cbrt_ref(xv);
      check("root", root, r);
      check("remainder", remainder, xv - r * r * r);
`ifdef CUBE_ROOT_EXACT_EN
      check("exact", exact, (xv == r * r * r) ? 1 : 0);
`endif
      if (chain) present(next_x);
      else begin
         start   = 1'b0;
         data_in = IN_W'($urandom);
      end
   endtask

   initial begin
      int r, x;
      rst_n   = 1'b0;
      start   = 1'b0;
      data_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_root", root, 0);
      check("rst_rem", remainder, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed values from the operand boundaries and known cubes.
      present(27);   run_op(27, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      check("idle_after_done", done, 0);
      present(4095); run_op(4095, 0, 0, 0, 3, 0);
      present(0);    run_op(0, 0, 0, 0, 15, 720);
      present(999);  run_op(999, 0, 0, 0, 0, 0);

      // start held high with another operand while busy: must be ignored.
      present(1000);
      @(posedge clk); #1;
      data_in = IN_W'(8);
      begin
         int lat = 1;
         int pulses = 0;
         while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
         check("hold_latency", lat, 9);
         check("hold_root", root, 10);
         check("hold_rem", remainder, 0);
         start = 1'b0;
         repeat (4) begin @(posedge clk); #1; if (done) pulses++; end
         check("hold_extra_done", pulses, 0);
      end

      // Back-to-back: accept 64 in the DONE cycle of 1000.
      present(1000); run_op(1000, 0, 1, 64, 10, 0);
      check("b2b_first_root", root, 10);
      run_op(64, 0, 0, 0, 10, 0);

      // Reset asserted mid-computation.
      present(4095);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_root", root, 0);
      check("abort_rem", remainder, 0);
      @(negedge clk); rst_n = 1'b1;
      begin
         int pulses = 0;
         repeat (12) begin @(posedge clk); #1; if (done) pulses++; end
         check("abort_no_done", pulses, 0);
      end
      present(125); run_op(125, 0, 0, 0, 0, 0);

      // Randomized operands with input noise during busy.
      r = 5; x = 0;
      repeat (200) begin
         int v = $urandom_range(4095, 0);
         present(v);
         run_op(v, 1, 0, 0, r, x);
         r = cbrt_ref(v); x = v - r * r * r;
      end

      // Exhaustive sweep, chained back-to-back.
      present(0);
      for (int v = 0; v < 4096; v++) begin
         run_op(v, 0, (v < 4095), v + 1, r, x);
         r = cbrt_ref(v); x = v - r * r * r;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
